// File: rtl/frame_reader_module_pkg.sv
// Shared frame geometry, DDR port encodings and Bayer lane constants.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
// Contents: FRAME_* geometry, ADDR/DATA/PIXEL widths, READ_LATENCY default,
//           LANE_* byte lanes of a packed DDR word, DDR_WREN_* encodings,
//           state_t for the reader FSM, pack_pixel() lane extraction.
package frame_reader_module_pkg;

    localparam int FRAME_WIDTH  = 320;
    localparam int FRAME_HEIGHT = 240;
    localparam int FRAME_WORDS  = FRAME_WIDTH * FRAME_HEIGHT;

    localparam int ADDR_WIDTH   = 20;
    localparam int DATA_WIDTH   = 32;
    localparam int PIXEL_WIDTH  = 24;
    localparam int READ_LATENCY = 2;

    // Byte lanes of one stored word: {B, G2, R, G1} from msb to lsb.
    localparam int LANE_G1 = 0;
    localparam int LANE_R  = 1;
    localparam int LANE_G2 = 2;
    localparam int LANE_B  = 3;

    // Shared DDR write-enable encoding: high means read / bus released.
    localparam logic DDR_WREN_READ  = 1'b1;
    localparam logic DDR_WREN_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Output pixel keeps {B, R, G1}; the second green sample is dropped,
    // matching the packing used on the capture side.
    function automatic logic [PIXEL_WIDTH-1:0] pack_pixel(input logic [DATA_WIDTH-1:0] word);
        return {word[LANE_B*8 +: 8], word[LANE_R*8 +: 8], word[LANE_G1*8 +: 8]};
    endfunction

endpackage

// File: rtl/frame_reader_module_if.sv
// DDR read port plus pixel stream bundle between the frame reader and its peers.
// Latency: n/a (wiring only).
// Backpressure: pixel stream is valid/ready; DDR side has no handshake of its own.
// master: reader side (drives ddr_addr/ddr_wren and pixel_data/valid/last).
// slave : memory/consumer side (drives data_read and pixel_ready).
interface frame_reader_module_if
    import frame_reader_module_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH,
    parameter int PW = PIXEL_WIDTH
);
    logic [AW-1:0] ddr_addr;
    logic          ddr_wren;
    logic [DW-1:0] data_read;
    logic [PW-1:0] pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          pixel_last;

    modport master (
        output ddr_addr,
        output ddr_wren,
        input  data_read,
        output pixel_data,
        output pixel_valid,
        input  pixel_ready,
        output pixel_last
    );

    modport slave (
        input  ddr_addr,
        input  ddr_wren,
        output data_read,
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready,
        input  pixel_last
    );
endinterface

// File: rtl/frame_reader_module_out_reg.sv
// Pixel output holding register with valid/last flags.
// Latency: load appears on the outputs one unpaused cycle later.
// Backpressure: data/valid/last held while valid && !ready; nothing moves while paused.
// Ports: clk/reset/pause; load/load_data/load_last capture a pixel; clear drops
//        valid/last (abort); ready from consumer; data/valid/last out; accept
//        pulses combinationally when a transfer completes on this cycle.
module frame_reader_out_reg #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             clear,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last,
    output logic             accept
);

    // A paused cycle never completes a transfer, whatever ready says.
    assign accept = valid && ready && !pause;

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (!pause) begin
            if (clear) begin
                valid <= 1'b0;
                last  <= 1'b0;
            end else if (load) begin
                data  <= load_data;
                valid <= 1'b1;
                last  <= load_last;
            end else if (accept) begin
                // data is left as-is; only the flags drop.
                valid <= 1'b0;
                last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frame_reader_module.sv
// Streams one stored Bayer-packed frame from DDR as a valid/ready pixel stream.
// Latency: first pixel READ_LATENCY+2 cycles after enable; then one per READ_LATENCY+2 with ready high.
// Backpressure: one read outstanding; next fetch waits for the held pixel to be accepted; pause freezes all.
// Ports: clk, reset (sync, active high), pause (freeze), frame_read_enable (level),
//        data_read_offset (frame base, sampled at start), bus (DDR read port +
//        pixel stream), frame_read_in_progress, frame_read_done, word_count.
module frame_reader_module #(
    parameter int FRAME_WORDS  = frame_reader_module_pkg::FRAME_WORDS,
    parameter int ADDR_WIDTH   = frame_reader_module_pkg::ADDR_WIDTH,
    parameter int READ_LATENCY = frame_reader_module_pkg::READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  frame_read_enable,
    input  logic [ADDR_WIDTH-1:0] data_read_offset,
    frame_reader_module_if.master bus,
    output logic                  frame_read_in_progress,
    output logic                  frame_read_done,
    output logic [ADDR_WIDTH-1:0] word_count
);
    import frame_reader_module_pkg::*;

    localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]      LAT_INIT = CNT_W'(READ_LATENCY);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] wc_q, wc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  inprog_q, inprog_d;
    logic                  done_q, done_d;

    logic                  abort;
    logic                  load;
    logic                  clear;
    logic                  accept;
    logic [PIXEL_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_last;

    // State and datapath registers; everything holds while paused.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            wc_q     <= '0;
            cnt_q    <= '0;
            inprog_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (!pause) begin
            state_q  <= state_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            wc_q     <= wc_d;
            cnt_q    <= cnt_d;
            inprog_q <= inprog_d;
            done_q   <= done_d;
        end
    end

    // Dropping enable mid-frame wins over any pending capture or accept, so
    // an in-flight read simply never gets loaded.
    assign abort = !frame_read_enable &&
                   (state_q == ST_ISSUE || state_q == ST_WAIT || state_q == ST_HOLD);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        addr_d   = addr_q;
        wc_d     = wc_q;
        cnt_d    = cnt_q;
        inprog_d = inprog_q;
        done_d   = done_q;
        load     = 1'b0;
        clear    = 1'b0;

        if (abort) begin
            state_d  = ST_IDLE;
            clear    = 1'b1;
            addr_d   = '0;
            wc_d     = '0;
            inprog_d = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_read_enable) begin
                        base_d   = data_read_offset;
                        wc_d     = '0;
                        inprog_d = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Sum wraps at the address width by construction.
                    addr_d  = base_q + wc_q;
                    cnt_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        load    = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        if (pix_last) begin
                            done_d   = 1'b1;
                            inprog_d = 1'b0;
                            addr_d   = '0;
                            state_d  = ST_DONE;
                        end else begin
                            wc_d    = wc_q + ADDR_WIDTH'(1);
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!frame_read_enable) begin
                        done_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    frame_reader_out_reg #(
        .WIDTH (PIXEL_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .pause     (pause),
        .load      (load),
        .load_data (pack_pixel(bus.data_read)),
        .load_last (wc_q == LAST_IDX),
        .clear     (clear),
        .ready     (bus.pixel_ready),
        .data      (pix_data),
        .valid     (pix_valid),
        .last      (pix_last),
        .accept    (accept)
    );

    assign bus.ddr_addr    = addr_q;
    assign bus.ddr_wren    = DDR_WREN_READ;
    assign bus.pixel_data  = pix_data;
    assign bus.pixel_valid = pix_valid;
    assign bus.pixel_last  = pix_last;

    assign frame_read_in_progress = inprog_q;
    assign frame_read_done        = done_q;
    assign word_count             = wc_q;

endmodule
